// File: rtl/uart_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_mem_port : MEM-stage RAM1/UART byte-bus port with UART handshake FSM. |
// | Optional UART_TIMEOUT_EN bounds wait states, sets sticky uart_err. Rev 1.0 |
// +----------------------------------------------------------------------------+
module uart_mem_port #(
  parameter int WR_PULSE_CYC = 2,
  parameter int RD_PULSE_CYC = 2,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        mem_conflict,
  output logic        uart_conflict,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_tbre,
  input  logic        uart_tsre,
  input  logic        uart_data_ready,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  output logic        uart_err
);

  localparam logic [15:0] c_data_addr = 16'hBF00;
  localparam logic [15:0] c_stat_addr = 16'hBF01;
  localparam int c_pulse_max = (WR_PULSE_CYC > RD_PULSE_CYC) ? WR_PULSE_CYC : RD_PULSE_CYC;
  localparam int c_cnt_w     = $clog2(c_pulse_max) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_wr_last = c_cnt_w'(WR_PULSE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_rd_last = c_cnt_w'(RD_PULSE_CYC - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_SETUP = 4'd1,
    ST_WR_PULSE = 4'd2,
    ST_WR_TBRE  = 4'd3,
    ST_WR_TSRE  = 4'd4,
    ST_RD_WAIT  = 4'd5,
    ST_RD_PULSE = 4'd6,
    ST_DONE     = 4'd7
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [15:0]          rdata_q, rdata_d;
  logic [7:0]           bus_dout_q, bus_dout_d;
  logic                 bus_oe_q, bus_oe_d;
  logic                 rdn_q, rdn_d;
  logic                 wrn_q, wrn_d;

  logic                 w_any_access;
  logic                 w_uart_req;
  logic                 w_stat_rd;
  logic                 w_unused;

`ifdef UART_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

  logic [c_tmo_w-1:0]   tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 w_wait_state;

  assign w_wait_state = (state_q == ST_RD_WAIT) | (state_q == ST_WR_TBRE) | (state_q == ST_WR_TSRE);
  assign uart_err     = err_q;
  assign w_unused     = ^wdata[15:8];
`else
  localparam logic c_unused_tmo = (TIMEOUT_CYC > 0);

  assign uart_err = 1'b0;
  assign w_unused = ^{wdata[15:8], c_unused_tmo};
`endif

  assign w_any_access  = mem_read | mem_write;
  assign w_uart_req    = w_any_access & (addr == c_data_addr);
  assign w_stat_rd     = mem_read & (addr == c_stat_addr);
  assign mem_conflict  = w_any_access & ~addr[15];
  // Active-low stall: asserted for the accepting IDLE cycle and every busy state.
  assign uart_conflict = ~(((state_q == ST_IDLE) & w_uart_req) |
                           ((state_q != ST_IDLE) & (state_q != ST_DONE)));
  assign rdata         = w_stat_rd ? {14'b0, uart_data_ready, uart_tbre & uart_tsre} : rdata_q;

  assign uart_rdn = rdn_q;
  assign uart_wrn = wrn_q;
  assign bus_dout = bus_dout_q;
  assign bus_oe   = bus_oe_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    bus_dout_d = bus_dout_q;
`ifdef UART_TIMEOUT_EN
    tmo_d      = '0;
    err_d      = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (w_uart_req) begin
          if (mem_write) begin
            state_d    = ST_WR_SETUP;
            bus_dout_d = wdata[7:0];
          end else begin
            state_d    = ST_RD_WAIT;
          end
        end
      end
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: begin
        cnt_d = cnt_q + c_cnt_one;
        if (cnt_q == c_wr_last) state_d = ST_WR_TBRE;
      end
      ST_WR_TBRE: if (uart_tbre) state_d = ST_WR_TSRE;
      ST_WR_TSRE: if (uart_tsre) state_d = ST_DONE;
      ST_RD_WAIT: if (uart_data_ready) state_d = ST_RD_PULSE;
      ST_RD_PULSE: begin
        cnt_d = cnt_q + c_cnt_one;
        if (cnt_q == c_rd_last) begin
          state_d = ST_DONE;
          rdata_d = {8'h00, bus_din};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_TIMEOUT_EN
    // A wait state that is still unsatisfied on its last allowed cycle bails out to DONE.
    if (w_wait_state && (state_d == state_q)) begin
      if (tmo_q == c_tmo_last) begin
        state_d = ST_DONE;
        err_d   = 1'b1;
        if (state_q == ST_RD_WAIT) rdata_d = 16'h00FF;
      end else begin
        tmo_d = tmo_q + c_tmo_one;
      end
    end
`endif

    if (state_d != state_q) cnt_d = '0;

    bus_oe_d = (state_d == ST_WR_SETUP) | (state_d == ST_WR_PULSE);
    wrn_d    = (state_d != ST_WR_PULSE);
    rdn_d    = (state_d != ST_RD_PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      bus_dout_q <= '0;
      bus_oe_q   <= 1'b0;
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
`ifdef UART_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bus_dout_q <= bus_dout_d;
      bus_oe_q   <= bus_oe_d;
      rdn_q      <= rdn_d;
      wrn_q      <= wrn_d;
`ifdef UART_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_port.sv
`default_nettype none
// Bench for uart_mem_port: combinational vector table, directed handshake sequences,
// and random UART transfers checked against a transfer-level timing model.
module tb_uart_mem_port;

  localparam int WR_PULSE_CYC = 2;
  localparam int RD_PULSE_CYC = 2;
  localparam int TIMEOUT_CYC  = 1024;
  localparam int XFER_LIMIT   = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        mem_conflict, uart_conflict;
  logic        uart_rdn, uart_wrn;
  logic        uart_tbre, uart_tsre, uart_data_ready;
  logic [7:0]  bus_din, bus_dout;
  logic        bus_oe, uart_err;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_rdata;

  uart_mem_port #(
    .WR_PULSE_CYC(WR_PULSE_CYC),
    .RD_PULSE_CYC(RD_PULSE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mem_conflict(mem_conflict), .uart_conflict(uart_conflict),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre), .uart_data_ready(uart_data_ready),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe), .uart_err(uart_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic        dr;
    logic        tbre;
    logic        tsre;
    logic        exp_mc;
    logic        exp_uc;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic drive_idle();
    mem_read = 1'b0; mem_write = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    uart_tbre = 1'b0; uart_tsre = 1'b0; uart_data_ready = 1'b0; bus_din = 8'h00;
  endtask

  // Combinational probe in IDLE; inputs are withdrawn before the next rising edge.
  task automatic comb_probe(input string name, input logic rd, input logic wr, input logic [15:0] a,
                            input logic dr, input logic tb, input logic ts,
                            input logic exp_mc, input logic exp_uc, input logic [15:0] exp_rd);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = 16'h1234;
    uart_data_ready = dr; uart_tbre = tb; uart_tsre = ts;
    #1;
    check1({name, " mem_conflict"}, mem_conflict, exp_mc);
    check1({name, " uart_conflict"}, uart_conflict, exp_uc);
    check16({name, " rdata"}, rdata, exp_rd);
    drive_idle();
  endtask

  // One UART transfer on BF00. Level inputs become true from busy cycle a (tbre / data_ready)
  // and b (tsre) onward; busy cycle 0 is the first cycle after the accepting IDLE cycle.
  task automatic do_xfer(input string tag, input logic is_wr, input logic also_rd, input logic [15:0] wd,
                         input int a, input int b, input int din_fix);
    logic [7:0] din [0:XFER_LIMIT];
    int busy_exp, busy, wrn_lo, rdn_lo, oe_cnt, first_wrn, first_rdn, ra;
    logic done;
    for (int i = 0; i <= XFER_LIMIT; i++) din[i] = (din_fix >= 0) ? 8'(din_fix) : 8'($urandom);
    ra = max2(a, 0);
    if (is_wr) busy_exp = max2(max2(1 + WR_PULSE_CYC, a) + 1, b) + 1;
    else       busy_exp = ra + 1 + RD_PULSE_CYC;

    @(negedge clk);
    mem_write = is_wr; mem_read = is_wr ? also_rd : 1'b1; addr = 16'hBF00; wdata = wd;
    uart_tbre = is_wr && (a <= -1); uart_tsre = is_wr && (b <= -1);
    uart_data_ready = !is_wr && (a <= -1); bus_din = 8'h00;
    #1;
    check1({tag, " accept stall"}, uart_conflict, 1'b0);

    busy = -1; wrn_lo = 0; rdn_lo = 0; oe_cnt = 0; first_wrn = -1; first_rdn = -1; done = 1'b0;
    for (int k = 0; k <= XFER_LIMIT && !done; k++) begin
      @(negedge clk);
      if (uart_conflict) begin
        done = 1'b1;
        busy = k;
        check1({tag, " wrn released"}, uart_wrn, 1'b1);
        check1({tag, " rdn released"}, uart_rdn, 1'b1);
        if (!is_wr) check16({tag, " rdata in DONE"}, rdata, {8'h00, din[ra + RD_PULSE_CYC]});
        drive_idle();
      end else begin
        if (!uart_wrn) begin
          if (first_wrn < 0) first_wrn = k;
          wrn_lo++;
        end
        if (!uart_rdn) begin
          if (first_rdn < 0) first_rdn = k;
          rdn_lo++;
        end
        if (bus_oe) begin
          oe_cnt++;
          check16({tag, " bus_dout"}, {8'h00, bus_dout}, {8'h00, wd[7:0]});
        end
        uart_tbre = is_wr && (k >= a);
        uart_tsre = is_wr && (k >= b);
        uart_data_ready = !is_wr && (k >= a);
        bus_din = din[k];
      end
    end

    if (!done) begin
      drive_idle();
      check1({tag, " completion within bound"}, 1'b0, 1'b1);
    end
    check16({tag, " busy cycles"}, 16'(busy), 16'(busy_exp));
    if (is_wr) begin
      check16({tag, " wrn low cycles"}, 16'(wrn_lo), 16'(WR_PULSE_CYC));
      check16({tag, " first wrn cycle"}, 16'(first_wrn), 16'd1);
      check16({tag, " bus_oe cycles"}, 16'(oe_cnt), 16'(1 + WR_PULSE_CYC));
      check16({tag, " rdn low cycles"}, 16'(rdn_lo), 16'd0);
    end else begin
      check16({tag, " rdn low cycles"}, 16'(rdn_lo), 16'(RD_PULSE_CYC));
      check16({tag, " first rdn cycle"}, 16'(first_rdn), 16'(ra + 1));
      check16({tag, " wrn low cycles"}, 16'(wrn_lo), 16'd0);
      check16({tag, " bus_oe cycles"}, 16'(oe_cnt), 16'd0);
      model_rdata = {8'h00, din[ra + RD_PULSE_CYC]};
    end

    @(negedge clk);
    check1({tag, " back to idle"}, uart_conflict, 1'b1);
    check16({tag, " rdata held"}, rdata, model_rdata);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'hBF01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002};
    vecs[1]  = '{1'b1, 1'b0, 16'hBF01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001};
    vecs[2]  = '{1'b1, 1'b0, 16'hBF01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003};
    vecs[3]  = '{1'b0, 1'b1, 16'hBF01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'hBF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 16'hBF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 16'hBF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};

    rst = 1'b1;
    drive_idle();
    model_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset rdn", uart_rdn, 1'b1);
    check1("reset wrn", uart_wrn, 1'b1);
    check1("reset bus_oe", bus_oe, 1'b0);
    check16("reset bus_dout", {8'h00, bus_dout}, 16'h0000);
    check1("reset uart_conflict", uart_conflict, 1'b1);
    check16("reset rdata", rdata, 16'h0000);
    check1("reset uart_err", uart_err, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      comb_probe($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].dr,
                 vecs[i].tbre, vecs[i].tsre, vecs[i].exp_mc, vecs[i].exp_uc, vecs[i].exp_rdata);

    // FSM must stay idle after a RAM-region store.
    @(negedge clk);
    check1("ram store leaves fsm idle", uart_conflict, 1'b1);
    check1("ram store no wrn", uart_wrn, 1'b1);

    do_xfer("wr41", 1'b1, 1'b0, 16'h0041, -1, -1, -1);
    do_xfer("rd5A", 1'b0, 1'b0, 16'h0000, 3, 0, 8'h5A);
    do_xfer("wr_both", 1'b1, 1'b1, 16'hAA96, 4, 2, -1);

    // Reset in the middle of the write pulse aborts the transfer.
    @(negedge clk);
    mem_write = 1'b1; addr = 16'hBF00; wdata = 16'h00C3;
    @(negedge clk);
    check1("abort setup bus_oe", bus_oe, 1'b1);
    check16("abort setup bus_dout", {8'h00, bus_dout}, 16'h00C3);
    @(negedge clk);
    check1("abort pulse wrn", uart_wrn, 1'b0);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    check1("abort wrn", uart_wrn, 1'b1);
    check1("abort bus_oe", bus_oe, 1'b0);
    check1("abort idle", uart_conflict, 1'b1);
    rst = 1'b0;
    model_rdata = 16'h0000;

    for (int t = 0; t < 20; t++) begin
      logic        rd, wr, dr, tb, ts, req;
      logic [15:0] a;
      int          sel;
      sel = $urandom_range(0, 2);
      a   = (sel == 0) ? 16'hBF01 : (sel == 1) ? {1'b0, 15'($urandom)} : {1'b1, 15'($urandom)};
      rd  = 1'($urandom); wr = 1'($urandom);
      dr  = 1'($urandom); tb = 1'($urandom); ts = 1'($urandom);
      req = (rd | wr) && (a == 16'hBF00);
      comb_probe($sformatf("rnd%0d comb", t), rd, wr, a, dr, tb, ts,
                 (rd | wr) && (a < 16'h8000), !req,
                 (rd && a == 16'hBF01) ? {14'b0, dr, tb & ts} : model_rdata);
      if ($urandom_range(0, 1) == 1)
        do_xfer($sformatf("rnd%0d wr", t), 1'b1, 1'($urandom), 16'($urandom),
                $urandom_range(0, 6) - 1, $urandom_range(0, 8) - 1, -1);
      else
        do_xfer($sformatf("rnd%0d rd", t), 1'b0, 1'b0, 16'h0000,
                $urandom_range(0, 6) - 1, 0, -1);
    end

`ifdef UART_TIMEOUT_EN
    begin
      int   busy;
      int   rdn_lo;
      logic done;
      @(negedge clk);
      mem_read = 1'b1; addr = 16'hBF00;
      busy = -1; rdn_lo = 0; done = 1'b0;
      for (int k = 0; k <= TIMEOUT_CYC + 20 && !done; k++) begin
        @(negedge clk);
        if (uart_conflict) begin
          done = 1'b1;
          busy = k;
          check16("timeout rdata", rdata, 16'h00FF);
          drive_idle();
        end else if (!uart_rdn) begin
          rdn_lo++;
        end
      end
      if (!done) drive_idle();
      check16("timeout busy cycles", 16'(busy), 16'(TIMEOUT_CYC));
      check16("timeout no rdn", 16'(rdn_lo), 16'd0);
      check1("timeout err set", uart_err, 1'b1);
      @(negedge clk);
      check1("timeout err sticky", uart_err, 1'b1);
    end
`else
    check1("uart_err tied low", uart_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
